// File: rtl/dmfb_phase_timer.sv
//============================================================================
// Module  : dmfb_phase_timer
// Brief   : Electrode-phase timer with four selectable periods, burst length,
//           pause, graceful stop, tick/done strobes and a period counter.
// Config  : DMFB_TIMER_MODE_SAFE_EN - defer modeSel changes to a period wrap.
// Revision: 1.0 - initial release
//============================================================================
`default_nettype none

module dmfb_phase_timer #(
  parameter int WIDTH   = 28,
  parameter int PERIOD0 = 3000000,
  parameter int PERIOD1 = 200000000,
  parameter int PERIOD2 = 6000000,
  parameter int PERIOD3 = 100000000,
  parameter int CNT_W   = 16
) (
  input  logic             clockIn,
  input  logic             reset_t,
  input  logic             start,
  input  logic             stop,
  input  logic             enable,
  input  logic [1:0]       modeSel,
  input  logic [CNT_W-1:0] burstLen,
  output logic             clockOut,
  output logic             tick,
  output logic             done,
  output logic             busy,
  output logic [CNT_W-1:0] periodCount
);

  // Periods below 2 cannot produce both a low and a high phase.
  localparam int c_P0 = (PERIOD0 < 2) ? 2 : PERIOD0;
  localparam int c_P1 = (PERIOD1 < 2) ? 2 : PERIOD1;
  localparam int c_P2 = (PERIOD2 < 2) ? 2 : PERIOD2;
  localparam int c_P3 = (PERIOD3 < 2) ? 2 : PERIOD3;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_stateNext;
  logic [WIDTH-1:0] r_counter;
  logic [WIDTH-1:0] w_counterNext;
  logic [WIDTH-1:0] w_period;
  logic [WIDTH-1:0] w_half;
  logic [1:0]       r_mode;
  logic [1:0]       w_modeNext;
  logic [1:0]       w_wrapMode;
  logic [CNT_W-1:0] r_burstLen;
  logic [CNT_W-1:0] w_burstNext;
  logic [CNT_W-1:0] w_countNext;
  logic [CNT_W-1:0] w_countIncr;
  logic             r_stopPend;
  logic             w_stopNext;
  logic             w_clockNext;
  logic             w_tickNext;
  logic             w_doneNext;
  logic             w_modeRestart;
  logic             w_burstEnd;

  always_comb begin
    w_period = WIDTH'(c_P0);
    case (r_mode)
      2'd0:    w_period = WIDTH'(c_P0);
      2'd1:    w_period = WIDTH'(c_P1);
      2'd2:    w_period = WIDTH'(c_P2);
      default: w_period = WIDTH'(c_P3);
    endcase
  end

  assign w_half      = w_period >> 1;
  assign w_countIncr = periodCount + CNT_W'(1);
  assign w_burstEnd  = ((r_burstLen != '0) && (w_countIncr == r_burstLen))
                       || r_stopPend || stop;
  assign busy        = (r_state == S_RUN);

  always_comb begin
`ifdef DMFB_TIMER_MODE_SAFE_EN
    w_modeRestart = 1'b0;
    w_wrapMode    = modeSel;
`else
    w_modeRestart = (modeSel != r_mode);
    w_wrapMode    = r_mode;
`endif
  end

  always_comb begin
    w_stateNext   = r_state;
    w_counterNext = r_counter;
    w_clockNext   = clockOut;
    w_tickNext    = 1'b0;
    w_doneNext    = 1'b0;
    w_countNext   = periodCount;
    w_modeNext    = r_mode;
    w_burstNext   = r_burstLen;
    w_stopNext    = r_stopPend;
    case (r_state)
      S_IDLE: begin
        // A stop arriving with start is dropped here.
        w_stopNext = 1'b0;
        if (start) begin
          w_modeNext    = modeSel;
          w_burstNext   = burstLen;
          w_counterNext = '0;
          w_clockNext   = 1'b0;
          w_countNext   = '0;
          w_stateNext   = S_RUN;
        end
      end
      default: begin
        if (stop) w_stopNext = 1'b1;
        if (enable) begin
          if (w_modeRestart) begin
            w_modeNext    = modeSel;
            w_counterNext = '0;
            w_clockNext   = 1'b0;
          end else if (r_counter == w_period - WIDTH'(1)) begin
            w_tickNext    = 1'b1;
            w_countNext   = w_countIncr;
            w_counterNext = '0;
            w_clockNext   = 1'b0;
            w_modeNext    = w_wrapMode;
            if (w_burstEnd) begin
              w_doneNext  = 1'b1;
              w_stopNext  = 1'b0;
              w_stateNext = S_IDLE;
            end
          end else begin
            w_counterNext = r_counter + WIDTH'(1);
            w_clockNext   = (w_counterNext >= w_half);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clockIn or negedge reset_t) begin
    if (!reset_t) begin
      r_state     <= S_IDLE;
      r_counter   <= '0;
      r_mode      <= 2'd0;
      r_burstLen  <= '0;
      r_stopPend  <= 1'b0;
      clockOut    <= 1'b0;
      tick        <= 1'b0;
      done        <= 1'b0;
      periodCount <= '0;
    end else begin
      r_state     <= w_stateNext;
      r_counter   <= w_counterNext;
      r_mode      <= w_modeNext;
      r_burstLen  <= w_burstNext;
      r_stopPend  <= w_stopNext;
      clockOut    <= w_clockNext;
      tick        <= w_tickNext;
      done        <= w_doneNext;
      periodCount <= w_countNext;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dmfb_phase_timer.sv
//============================================================================
// Module  : tb_dmfb_phase_timer
// Brief   : Directed self-checking bench for dmfb_phase_timer (P = 4/6/10/3).
// Revision: 1.0 - initial release
//============================================================================
`default_nettype none

module tb_dmfb_phase_timer;

  logic       clockIn = 1'b0;
  logic       reset_t;
  logic       start;
  logic       stop;
  logic       enable;
  logic [1:0] modeSel;
  logic [7:0] burstLen;
  logic       clockOut;
  logic       tick;
  logic       done;
  logic       busy;
  logic [7:0] periodCount;

  int total = 0;
  int bad   = 0;

  always #5 clockIn = ~clockIn;

  dmfb_phase_timer #(
    .WIDTH  (8),
    .PERIOD0(4),
    .PERIOD1(6),
    .PERIOD2(10),
    .PERIOD3(3),
    .CNT_W  (8)
  ) dut (
    .clockIn    (clockIn),
    .reset_t    (reset_t),
    .start      (start),
    .stop       (stop),
    .enable     (enable),
    .modeSel    (modeSel),
    .burstLen   (burstLen),
    .clockOut   (clockOut),
    .tick       (tick),
    .done       (done),
    .busy       (busy),
    .periodCount(periodCount)
  );

  task automatic step();
    @(posedge clockIn);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [1:0] mode, input logic [7:0] len);
    modeSel  = mode;
    burstLen = len;
    start    = 1'b1;
    step();
    start    = 1'b0;
  endtask

  initial begin
    int  oddClk [7];
    logic expTick, expDone, expClk;
    oddClk = '{0, 1, 1, 0, 1, 1, 0};

    reset_t = 1'b0; start = 1'b0; stop = 1'b0; enable = 1'b1;
    modeSel = 2'd0; burstLen = 8'd0;
    #2;
    chk("rst_clockOut", clockOut, 0);
    chk("rst_tick", tick, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_periodCount", periodCount, 0);
    step(); step();
    @(negedge clockIn) reset_t = 1'b1;
    step();
    chk("idle_busy", busy, 0);

    // Basic burst: mode 0, three periods of 4.
    launch(2'd0, 8'd3);
    chk("basic_busy0", busy, 1);
    chk("basic_clk0", clockOut, 0);
    for (int k = 1; k <= 12; k++) begin
      step();
      chk($sformatf("basic_clk%0d", k), clockOut, 32'((k % 4) >= 2));
      chk($sformatf("basic_tick%0d", k), tick, 32'((k % 4) == 0));
      chk($sformatf("basic_done%0d", k), done, 32'(k == 12));
      chk($sformatf("basic_busy%0d", k), busy, 32'(k < 12));
    end
    chk("basic_count", periodCount, 3);
    step();
    chk("basic_done_pulse", done, 0);
    chk("basic_count_held", periodCount, 3);

    // Odd period: mode 3, two periods of 3.
    launch(2'd3, 8'd2);
    chk("odd_clk0", clockOut, 0);
    for (int k = 1; k <= 6; k++) begin
      step();
      chk($sformatf("odd_clk%0d", k), clockOut, 32'(oddClk[k]));
      chk($sformatf("odd_done%0d", k), done, 32'(k == 6));
    end
    chk("odd_count", periodCount, 2);

    // Stop at counter 2 of the second 6-clock period.
    launch(2'd1, 8'd0);
    for (int k = 1; k <= 12; k++) begin
      stop = (k == 9);
      step();
      chk($sformatf("stop_tick%0d", k), tick, 32'(k == 6 || k == 12));
      chk($sformatf("stop_done%0d", k), done, 32'(k == 12));
    end
    stop = 1'b0;
    chk("stop_count", periodCount, 2);
    chk("stop_clk", clockOut, 0);
    chk("stop_busy", busy, 0);

    // Pause for 5 clocks at counter 2 of mode 0.
    launch(2'd0, 8'd2);
    for (int k = 1; k <= 13; k++) begin
      enable = !(k >= 3 && k <= 7);
      step();
      if (k >= 3 && k <= 7) chk($sformatf("pause_clk%0d", k), clockOut, 1);
      chk($sformatf("pause_tick%0d", k), tick, 32'(k == 9 || k == 13));
      chk($sformatf("pause_done%0d", k), done, 32'(k == 13));
    end
    enable = 1'b1;
    chk("pause_count", periodCount, 2);

    // Asynchronous reset in the middle of a free-running burst.
    launch(2'd0, 8'd0);
    repeat (6) step();
    chk("pre_rst_count", periodCount, 1);
    chk("pre_rst_clk", clockOut, 1);
    chk("pre_rst_busy", busy, 1);
    #2 reset_t = 1'b0;
    #1;
    chk("arst_clk", clockOut, 0);
    chk("arst_busy", busy, 0);
    chk("arst_count", periodCount, 0);
    chk("arst_tick", tick, 0);
    chk("arst_done", done, 0);
    @(negedge clockIn) reset_t = 1'b1;
    step();
    chk("post_rst_busy", busy, 0);
    launch(2'd0, 8'd1);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk($sformatf("post_rst_done%0d", k), done, 32'(k == 4));
    end
    chk("post_rst_count", periodCount, 1);

    // Mode switch 0 -> 2 while counter reads 1.
    launch(2'd0, 8'd2);
    step();
    modeSel = 2'd2;
    for (int k = 2; k <= 22; k++) begin
      step();
`ifdef DMFB_TIMER_MODE_SAFE_EN
      expTick = (k == 4 || k == 14);
      expDone = (k == 14);
      expClk  = (k < 4) ? 1'b1 : (k < 14) ? ((k - 4) >= 5) : 1'b0;
`else
      expTick = (k == 12 || k == 22);
      expDone = (k == 22);
      expClk  = (k < 22) ? (((k - 2) % 10) >= 5) : 1'b0;
`endif
      chk($sformatf("mode_tick%0d", k), tick, 32'(expTick));
      chk($sformatf("mode_done%0d", k), done, 32'(expDone));
      chk($sformatf("mode_clk%0d", k), clockOut, 32'(expClk));
    end
    chk("mode_count", periodCount, 2);

    // start+stop together in IDLE; start in RUN is ignored.
    modeSel  = 2'd3;
    burstLen = 8'd2;
    start    = 1'b1;
    stop     = 1'b1;
    step();
    stop     = 1'b0;
    burstLen = 8'd0;
    for (int k = 1; k <= 6; k++) begin
      start = (k == 1);
      step();
      chk($sformatf("ss_done%0d", k), done, 32'(k == 6));
    end
    start = 1'b0;
    chk("ss_count", periodCount, 2);
    chk("ss_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
